// File: rtl/enc_pkg.sv
// Shared definitions for the serial priority event encoder.
package enc_pkg;

  // Priority modes for the slot arbiter
  localparam int ENC_LSB = 0;
  localparam int ENC_MSB = 1;
  localparam int ENC_RR  = 2;

  // Output slot state; PRESENT means out_idx carries an unaccepted event
  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_PRESENT = 1'b1
  } slot_state_t;

  // Ceiling log2, minimum result 1 so a 2-line encoder still gets a 1-bit index
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    if (res < 1) res = 1;
    return res;
  endfunction

endpackage

// File: rtl/enc_pri_sel.sv
// Combinational one-of-N selector: lowest set bit at or above base (wrapping),
// or highest set bit when msb_first is set (base ignored in that case).
module enc_pri_sel
  import enc_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] base,
  input  logic             msb_first,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W-1:0] hi;
  logic [IDX_W:0]   sum;

  // Rotate the request vector down by base, find the first set bit, then undo the rotation
  always_comb begin
    any = |vec;
    dbl = {vec, vec} >> base;
    rot = dbl[N-1:0];
    off = '0;
    hi  = '0;
    // descending scan so the lowest set bit of the rotated vector is kept
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    // ascending scan so the highest set bit of the raw vector is kept
    for (int i = 0; i < N; i++) begin
      if (vec[i]) hi = IDX_W'(i);
    end
    // modular add; explicit wrap because N need not be a power of two
    sum = {1'b0, off} + {1'b0, base};
    if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
    idx = msb_first ? hi : sum[IDX_W-1:0];
  end

endmodule

// File: rtl/encoder_serial_pri.sv
// N-line event encoder: captures request pulses into a pending vector and
// presents one index per transfer on a registered valid/ready slot.
module encoder_serial_pri
  import enc_pkg::*;
#(
  parameter int N        = 8,
  parameter int ARB_MODE = ENC_LSB
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [clog2(N)-1:0]    out_idx,
  output logic [N-1:0]           pending_o,
  output logic                   drop_o
);

  localparam int IDX_W = clog2(N);

  slot_state_t      state_reg;
  logic [N-1:0]     pending_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic             drop_reg;

  logic             load;
  logic [N-1:0]     cand;
  logic             sel_any;
  logic [IDX_W-1:0] sel_idx;
  logic [N-1:0]     sel_mask;
  logic [IDX_W-1:0] sel_base;
  logic [IDX_W-1:0] ptr_next;
  logic             drop_next;

  assign load      = (state_reg == ST_EMPTY) || out_ready;
  assign cand      = pending_reg | req_i;
  assign sel_base  = (ARB_MODE == ENC_RR) ? ptr_reg : '0;
  assign sel_mask  = N'(1) << sel_idx;
  assign ptr_next  = (sel_idx == IDX_W'(N - 1)) ? '0 : sel_idx + IDX_W'(1);

  enc_pri_sel #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_sel (
    .vec       (cand),
    .base      (sel_base),
    .msb_first (ARB_MODE == ENC_MSB),
    .any       (sel_any),
    .idx       (sel_idx)
  );

  // A request that lands on an already-pending line merges and is lost, unless it is the winner
  always_comb begin
    drop_next = 1'b0;
    if (load && sel_any) drop_next = |(req_i & pending_reg & ~sel_mask);
    else                 drop_next = |(req_i & pending_reg);
  end

  // Slot FSM, pending capture, round-robin pointer and drop flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_EMPTY;
      pending_reg <= '0;
      idx_reg     <= '0;
      ptr_reg     <= '0;
      drop_reg    <= 1'b0;
    end else begin
      drop_reg <= drop_next;
      if (load) begin
        if (sel_any) begin
          state_reg   <= ST_PRESENT;
          idx_reg     <= sel_idx;
          pending_reg <= cand & ~sel_mask;
          ptr_reg     <= ptr_next;
        end else begin
          state_reg   <= ST_EMPTY;
          pending_reg <= cand;
        end
      end else begin
        // held slot: index and valid stay frozen, new events only accumulate
        pending_reg <= cand;
      end
    end
  end

  assign out_valid = (state_reg == ST_PRESENT);
  assign out_idx   = idx_reg;
  assign pending_o = pending_reg;
  assign drop_o    = drop_reg;

endmodule

// File: tb/tb_encoder_serial_pri.sv
// Directed bench for encoder_serial_pri: three N=8 instances (LSB, MSB, RR)
// share stimulus, plus an N=5 round-robin instance for the wrap case.
module tb_encoder_serial_pri;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req8 = '0;
  logic       rdy8 = 1'b0;
  logic [4:0] req5 = '0;
  logic       rdy5 = 1'b0;

  logic       v0, v1, v2, v5;
  logic [2:0] i0, i1, i2, i5;
  logic [7:0] p0, p1, p2;
  logic [4:0] p5;
  logic       d0, d1, d2, d5;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  encoder_serial_pri #(.N(8), .ARB_MODE(0)) u_lsb (
    .clk(clk), .rst(rst), .req_i(req8), .out_valid(v0), .out_ready(rdy8),
    .out_idx(i0), .pending_o(p0), .drop_o(d0));

  encoder_serial_pri #(.N(8), .ARB_MODE(1)) u_msb (
    .clk(clk), .rst(rst), .req_i(req8), .out_valid(v1), .out_ready(rdy8),
    .out_idx(i1), .pending_o(p1), .drop_o(d1));

  encoder_serial_pri #(.N(8), .ARB_MODE(2)) u_rr (
    .clk(clk), .rst(rst), .req_i(req8), .out_valid(v2), .out_ready(rdy8),
    .out_idx(i2), .pending_o(p2), .drop_o(d2));

  encoder_serial_pri #(.N(5), .ARB_MODE(2)) u_rr5 (
    .clk(clk), .rst(rst), .req_i(req5), .out_valid(v5), .out_ready(rdy5),
    .out_idx(i5), .pending_o(p5), .drop_o(d5));

  // advance one clock; outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req8 = '0;
    req5 = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({v0, v1, v2, v5} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_valid: got %b want 0000", {v0, v1, v2, v5});
    end
    n_cmp++;
    if ({p0, p1, p2, p5, d0, d1, d2, d5, i0, i1, i2, i5} !== '0) begin
      n_err++;
      $display("FAIL reset_regs: pend %h %h %h %h drop %b%b%b%b idx %0d %0d %0d %0d want all 0",
               p0, p1, p2, p5, d0, d1, d2, d5, i0, i1, i2, i5);
    end
  endtask

  task automatic test_lsb_burst();
    logic [2:0] ei [3] = '{3'd2, 3'd5, 3'd7};
    logic [7:0] ep [3] = '{8'hA0, 8'h80, 8'h00};
    do_reset();
    rdy8 = 1'b1;
    req8 = 8'hA4;
    tick();
    req8 = 8'h00;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (v0 !== 1'b1 || i0 !== ei[k] || p0 !== ep[k]) begin
        n_err++;
        $display("FAIL lsb_burst[%0d]: valid %b idx %0d pend %h want 1 %0d %h", k, v0, i0, p0, ei[k], ep[k]);
      end
      tick();
    end
    n_cmp++;
    if (v0 !== 1'b0) begin
      n_err++;
      $display("FAIL lsb_burst_empty: valid %b want 0", v0);
    end
    $display("lsb_burst: done");
  endtask

  task automatic test_msb_burst();
    logic [2:0] ei [3] = '{3'd7, 3'd5, 3'd2};
    logic [7:0] ep [3] = '{8'h24, 8'h04, 8'h00};
    do_reset();
    rdy8 = 1'b1;
    req8 = 8'hA4;
    tick();
    req8 = 8'h00;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (v1 !== 1'b1 || i1 !== ei[k] || p1 !== ep[k] || d1 !== 1'b0) begin
        n_err++;
        $display("FAIL msb_burst[%0d]: valid %b idx %0d pend %h drop %b want 1 %0d %h 0",
                 k, v1, i1, p1, d1, ei[k], ep[k]);
      end
      tick();
    end
    n_cmp++;
    if (v1 !== 1'b0 || d1 !== 1'b0) begin
      n_err++;
      $display("FAIL msb_burst_empty: valid %b drop %b want 0 0", v1, d1);
    end
    $display("msb_burst: done");
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy8 = 1'b0;
    req8 = 8'h04;
    tick();
    req8 = 8'h00;
    // five samples of the same held event
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (v0 !== 1'b1 || i0 !== 3'd2 || p0 !== 8'h00) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: valid %b idx %0d pend %h want 1 2 00", k, v0, i0, p0);
      end
      if (k < 4) tick();
    end
    req8 = 8'h04;
    tick();
    req8 = 8'h00;
    n_cmp++;
    if (p0 !== 8'h04 || d0 !== 1'b0 || i0 !== 3'd2 || v0 !== 1'b1) begin
      n_err++;
      $display("FAIL bp_rereq: pend %h drop %b idx %0d valid %b want 04 0 2 1", p0, d0, i0, v0);
    end
    req8 = 8'h04;
    tick();
    req8 = 8'h00;
    n_cmp++;
    if (d0 !== 1'b1 || p0 !== 8'h04) begin
      n_err++;
      $display("FAIL bp_drop: drop %b pend %h want 1 04", d0, p0);
    end
    tick();
    n_cmp++;
    if (d0 !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drop_pulse: drop %b want 0", d0);
    end
    rdy8 = 1'b1;
    tick();
    n_cmp++;
    if (v0 !== 1'b1 || i0 !== 3'd2 || p0 !== 8'h00) begin
      n_err++;
      $display("FAIL bp_release: valid %b idx %0d pend %h want 1 2 00", v0, i0, p0);
    end
    tick();
    n_cmp++;
    if (v0 !== 1'b0) begin
      n_err++;
      $display("FAIL bp_empty: valid %b want 0", v0);
    end
    $display("backpressure: done");
  endtask

  task automatic test_round_robin();
    do_reset();
    rdy8 = 1'b1;
    req8 = 8'h03;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++;
      if (v2 !== 1'b1 || i2 !== 3'(k % 2)) begin
        n_err++;
        $display("FAIL rr_alt[%0d]: valid %b idx %0d want 1 %0d", k, v2, i2, k % 2);
      end
      n_cmp++;
      if (v0 !== 1'b1 || i0 !== 3'd0 || p0[1] !== 1'b1) begin
        n_err++;
        $display("FAIL rr_fixed[%0d]: valid %b idx %0d pend %h want 1 0 pend[1]=1", k, v0, i0, p0);
      end
    end
    req8 = 8'h00;
    $display("round_robin: done");
  endtask

  task automatic test_reset_midop();
    do_reset();
    rdy8 = 1'b0;
    req8 = 8'h08;
    tick();
    req8 = 8'hF0;
    tick();
    n_cmp++;
    if (v2 !== 1'b1 || i2 !== 3'd3 || p2 !== 8'hF0) begin
      n_err++;
      $display("FAIL midop_setup: valid %b idx %0d pend %h want 1 3 F0", v2, i2, p2);
    end
    // requests during the reset cycle must be ignored
    rst  = 1'b1;
    req8 = 8'hFF;
    tick();
    rst  = 1'b0;
    req8 = 8'h00;
    n_cmp++;
    if (v2 !== 1'b0 || p2 !== 8'h00 || d2 !== 1'b0) begin
      n_err++;
      $display("FAIL midop_reset: valid %b pend %h drop %b want 0 00 0", v2, p2, d2);
    end
    rdy8 = 1'b1;
    req8 = 8'h81;
    tick();
    req8 = 8'h00;
    n_cmp++;
    if (v2 !== 1'b1 || i2 !== 3'd0 || p2 !== 8'h80) begin
      n_err++;
      $display("FAIL midop_rr_restart: valid %b idx %0d pend %h want 1 0 80", v2, i2, p2);
    end
    tick();
    n_cmp++;
    if (v2 !== 1'b1 || i2 !== 3'd7) begin
      n_err++;
      $display("FAIL midop_rr_next: valid %b idx %0d want 1 7", v2, i2);
    end
    $display("reset_midop: done");
  endtask

  task automatic test_rr_wrap_n5();
    do_reset();
    rdy5 = 1'b1;
    req5 = 5'b10001;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++;
      if (v5 !== 1'b1 || i5 !== ((k % 2 == 1) ? 3'd4 : 3'd0)) begin
        n_err++;
        $display("FAIL n5_wrap[%0d]: valid %b idx %0d want 1 %0d", k, v5, i5, (k % 2 == 1) ? 4 : 0);
      end
      n_cmp++;
      if (i5 > 3'd4) begin
        n_err++;
        $display("FAIL n5_range[%0d]: idx %0d want <= 4", k, i5);
      end
    end
    req5 = 5'b00000;
    $display("rr_wrap_n5: done");
  endtask

  initial begin
    test_reset();
    test_lsb_burst();
    test_msb_burst();
    test_backpressure();
    test_round_robin();
    test_reset_midop();
    test_rr_wrap_n5();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
